// File: rtl/qe_pkg.sv
// qe_pkg: shared state/step types, default widths and the quadrature step decoder
package qe_pkg;
    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_RUN} qe_dec_state_t;
    typedef enum logic [1:0] {STEP_NONE, STEP_FWD, STEP_REV, STEP_ILLEGAL} step_t;
    localparam int QE_SYNC_STAGES = 2;
    localparam int QE_COUNT_W = 32;
    localparam int QE_PERIOD_W = 32;
    // {A,B} maps onto a 2-bit Gray phase {B, A^B}; the phase delta mod 4 classifies the move
    function automatic step_t decode_step(input logic [1:0] prev_ab, input logic [1:0] ab);
        logic [1:0] d;
        d = {ab[0], ^ab} - {prev_ab[0], ^prev_ab};
        return d == 2'd1 ? STEP_FWD : d == 2'd3 ? STEP_REV : d == 2'd2 ? STEP_ILLEGAL : STEP_NONE;
    endfunction
endpackage

// File: rtl/qe_sync.sv
// qe_sync: multi-flop input synchroniser with registered previous value and rising-edge flag
module qe_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q,
    output logic q_prev,
    output logic rise
);
    logic [SYNC_STAGES-1:0] chain;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            chain <= '0;
            q_prev <= 1'b0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], d};
            q_prev <= chain[SYNC_STAGES-1];
        end
    end
    assign q = chain[SYNC_STAGES-1];
    assign rise = q & ~q_prev;
endmodule

// File: rtl/qe_decoder.sv
// qe_decoder: x4 quadrature decoder with position, index capture, step period and error flags
// QE_INDEX_CLEAR_EN: an index rising edge also zeroes position after index_position captures it
module qe_decoder
    import qe_pkg::*;
#(
    parameter int SYNC_STAGES = QE_SYNC_STAGES,
    parameter int COUNT_W = QE_COUNT_W,
    parameter int PERIOD_W = QE_PERIOD_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               qe_a,
    input  logic               qe_b,
    input  logic               qe_index,
    input  logic               clear_count,
    output logic [COUNT_W-1:0] position,
    output logic [COUNT_W-1:0] index_position,
    output logic               direction,
    output logic [PERIOD_W-1:0] period,
    output logic               step_strobe,
    output logic               index_seen,
    output logic               error,
    output logic               stalled
);
    logic a_q, a_prev, b_q, b_prev, idx_rise;
    logic unused_a_rise, unused_b_rise, unused_idx_q, unused_idx_prev;
    logic [SYNC_STAGES-1:0] settle;
    qe_dec_state_t state;
    logic [PERIOD_W-1:0] period_cnt;
    step_t step;
    logic live, take, idx_ev, index_blocks, illegal, sat;

    qe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_a (
        .clk(clk), .reset(reset), .d(qe_a), .q(a_q), .q_prev(a_prev), .rise(unused_a_rise)
    );
    qe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_b (
        .clk(clk), .reset(reset), .d(qe_b), .q(b_q), .q_prev(b_prev), .rise(unused_b_rise)
    );
    qe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_idx (
        .clk(clk), .reset(reset), .d(qe_index), .q(unused_idx_q), .q_prev(unused_idx_prev), .rise(idx_rise)
    );

    always_comb begin
        step = decode_step({a_prev, b_prev}, {a_q, b_q});
        live = enable && state != S_IDLE;
        idx_ev = enable && idx_rise;
`ifdef QE_INDEX_CLEAR_EN
        index_blocks = idx_ev;
`else
        index_blocks = 1'b0;
`endif
        take = live && !clear_count && !index_blocks && (step == STEP_FWD || step == STEP_REV);
        illegal = live && step == STEP_ILLEGAL;
        sat = enable && state == S_RUN && !take && &period_cnt;
    end

    // settle holds the FSM in S_IDLE until the synchronisers carry real samples after reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            settle <= '0;
            period_cnt <= '0;
            position <= '0;
            index_position <= '0;
            direction <= 1'b0;
            period <= '0;
            step_strobe <= 1'b0;
            index_seen <= 1'b0;
            error <= 1'b0;
            stalled <= 1'b0;
        end else begin
            settle <= {settle[SYNC_STAGES-2:0], 1'b1};
            step_strobe <= take;
            if (take)
                direction <= step == STEP_FWD;
            if (idx_ev) begin
                index_position <= position;
                index_seen <= 1'b1;
            end
            position <= (clear_count || index_blocks) ? '0 :
                        take ? position + (step == STEP_FWD ? COUNT_W'(1) : {COUNT_W{1'b1}}) : position;
            error <= !clear_count && (error || illegal);
            stalled <= !clear_count && !take && (stalled || sat);
            if (!enable) begin
                state <= S_IDLE;
                period_cnt <= '0;
            end else begin
                case (state)
                    S_IDLE: if (settle[SYNC_STAGES-1]) state <= S_ARMED;
                    S_ARMED: if (take) begin
                        period_cnt <= PERIOD_W'(1);
                        state <= S_RUN;
                    end
                    S_RUN: if (take) begin
                        period <= period_cnt;
                        period_cnt <= PERIOD_W'(1);
                    end else if (sat) begin
                        period <= '1;
                        period_cnt <= '0;
                        state <= S_ARMED;
                    end else
                        period_cnt <= period_cnt + PERIOD_W'(1);
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_qe_decoder.sv
// tb_qe_decoder: directed self-checking bench for qe_decoder (32-bit and 8-bit period instances)
module tb_qe_decoder;
    logic clk = 1'b0, reset, enable, en8, qe_index, clear_count;
    logic [1:0] ab;
    logic [31:0] position, index_position, position8, index_position8;
    logic [31:0] period;
    logic [7:0] period8;
    logic direction, step_strobe, index_seen, error, stalled;
    logic direction8, strobe8, seen8, error8, stalled8;
    int checks = 0, errors = 0, strobes = 0, s0, gi;
    logic [1:0] gray_ab [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
`ifdef QE_INDEX_CLEAR_EN
    localparam logic [31:0] IDX_POS = 32'd0;
`else
    localparam logic [31:0] IDX_POS = 32'd7;
`endif

    always #5 clk = ~clk;

    qe_decoder dut (
        .clk(clk), .reset(reset), .enable(enable), .qe_a(ab[1]), .qe_b(ab[0]), .qe_index(qe_index),
        .clear_count(clear_count), .position(position), .index_position(index_position),
        .direction(direction), .period(period), .step_strobe(step_strobe), .index_seen(index_seen),
        .error(error), .stalled(stalled)
    );

    qe_decoder #(.PERIOD_W(8)) u_p8 (
        .clk(clk), .reset(reset), .enable(en8), .qe_a(ab[1]), .qe_b(ab[0]), .qe_index(qe_index),
        .clear_count(clear_count), .position(position8), .index_position(index_position8),
        .direction(direction8), .period(period8), .step_strobe(strobe8), .index_seen(seen8),
        .error(error8), .stalled(stalled8)
    );

    always @(negedge clk) if (step_strobe) strobes++;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic fwd();
        gi = (gi + 1) % 4;
        ab = gray_ab[gi];
    endtask

    task automatic rev();
        gi = (gi + 3) % 4;
        ab = gray_ab[gi];
    endtask

    initial begin
        reset = 1'b0; enable = 1'b1; en8 = 1'b0; ab = 2'b00; gi = 0; qe_index = 1'b0; clear_count = 1'b0;
        tick(3);
        chk("rst_position", position, 0);
        chk("rst_period", period, 0);
        chk("rst_strobe", step_strobe, 0);
        chk("rst_error", error, 0);
        chk("rst_index_seen", index_seen, 0);
        chk("rst_stalled", stalled, 0);
        reset = 1'b1;
        tick(5);
        s0 = strobes;
        for (int k = 0; k < 4; k++) begin
            fwd();
            tick(3);
            chk("fwd_strobe", step_strobe, 1);
            chk("fwd_position", position, k + 1);
            chk("fwd_period", period, k == 0 ? 0 : 10);
            tick(7);
        end
        chk("fwd_direction", direction, 1);
        chk("fwd_strobe_low", step_strobe, 0);
        chk("fwd_strobe_count", strobes - s0, 4);
        chk("fwd_error", error, 0);
        clear_count = 1'b1;
        tick(1);
        clear_count = 1'b0;
        chk("clr_position", position, 0);
        for (int k = 0; k < 4; k++) begin
            rev();
            tick(3);
            chk("rev_position", position, 32'(-(k + 1)));
            chk("rev_period", period, k == 0 ? 11 : 10);
            tick(7);
        end
        chk("rev_direction", direction, 0);
        chk("rev_final", position, 32'hFFFF_FFFC);
        s0 = strobes;
        gi = 2;
        ab = gray_ab[gi];
        tick(3);
        chk("ill_error", error, 1);
        chk("ill_strobe", step_strobe, 0);
        chk("ill_position", position, 32'hFFFF_FFFC);
        chk("ill_period", period, 10);
        tick(2);
        chk("ill_no_strobe", strobes - s0, 0);
        clear_count = 1'b1;
        tick(1);
        clear_count = 1'b0;
        chk("ill_clr_error", error, 0);
        chk("ill_clr_position", position, 0);
        for (int k = 0; k < 7; k++) begin
            fwd();
            tick(4);
        end
        chk("pre_idx_position", position, 7);
        qe_index = 1'b1;
        tick(3);
        chk("idx_position", index_position, 7);
        chk("idx_seen", index_seen, 1);
        chk("idx_pos_after", position, IDX_POS);
        qe_index = 1'b0;
        tick(2);
        clear_count = 1'b1;
        tick(1);
        clear_count = 1'b0;
        for (int k = 0; k < 5; k++) begin
            fwd();
            tick(4);
        end
        chk("pre_clrstep_position", position, 5);
        fwd();
        tick(2);
        clear_count = 1'b1;
        tick(1);
        clear_count = 1'b0;
        chk("clrstep_position", position, 0);
        tick(3);
        chk("clrstep_hold", position, 0);
        chk("clrstep_idx_kept", index_position, 7);
        en8 = 1'b1;
        tick(3);
        fwd();
        tick(3);
        chk("p8_first_position", position8, 1);
        chk("p8_first_period", period8, 0);
        tick(254);
        chk("p8_not_stalled", stalled8, 0);
        tick(1);
        chk("p8_stalled", stalled8, 1);
        chk("p8_sat_period", period8, 8'hFF);
        fwd();
        tick(3);
        chk("p8_rearm_position", position8, 2);
        chk("p8_rearm_period", period8, 8'hFF);
        reset = 1'b0;
        #1;
        chk("mid_rst_position", position, 0);
        chk("mid_rst_index_position", index_position, 0);
        chk("mid_rst_index_seen", index_seen, 0);
        chk("mid_rst_period", period, 0);
        chk("mid_rst_direction", direction, 0);
        chk("mid_rst_p8_stalled", stalled8, 0);
        fwd();
        tick(2);
        reset = 1'b1;
        s0 = strobes;
        tick(6);
        chk("post_rst_position", position, 0);
        chk("post_rst_strobes", strobes - s0, 0);
        chk("post_rst_error", error, 0);
        fwd();
        tick(3);
        chk("post_rst_step", position, 1);
        chk("post_rst_direction", direction, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
